// File: rtl/servo_pwm_array.sv
// Multi-channel RC-servo pulse generator: shared 20 ms frame, per-channel shadowed command, slew-limited width.
// Latency: command applied at next frame boundary, pulse registered 1 clk after frame_start; no backpressure, writes always accepted.
module servo_pwm_array #(
    parameter int NUM_CH      = 4,
    parameter int CMD_W       = 6,
    parameter int CLK_HZ      = 100000000,
    parameter int SIMULATE    = 0,
    parameter int POS_STEP_US = 15,
    parameter int ROT_STEP_US = 7,
    parameter int SLEW_US     = 64,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic              wr_mode_i,
    input  logic              wr_dir_i,
    input  logic [CMD_W-1:0]  wr_cmd_i,
    input  logic              wr_ena_i,
    output logic [NUM_CH-1:0] pulse_o,
    output logic              frame_start_o
);

    localparam int DIV   = (SIMULATE != 0) ? 1 : CLK_HZ / 1000000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef struct packed {
        logic             mode;
        logic             dir;
        logic [CMD_W-1:0] cmd;
        logic             ena;
    } shadow_t;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [14:0]       frame_us_q, frame_us_d;
    logic              frame_start_q, frame_start_d;
    logic              tick, wrap;
    shadow_t           shadow_q [NUM_CH];
    shadow_t           shadow_d [NUM_CH];
    logic [14:0]       target_q [NUM_CH];
    logic [14:0]       target_d [NUM_CH];
    logic [14:0]       cur_w_q  [NUM_CH];
    logic [14:0]       cur_w_d  [NUM_CH];
    logic [NUM_CH-1:0] ena_q, ena_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;

    // Unsigned 15-bit width arithmetic, then clamp to the servo-safe range.
    function automatic logic [14:0] calc_target(input shadow_t s);
        logic [14:0] mag;
        logic [14:0] w;
        mag = 15'(s.cmd) * 15'(s.mode ? ROT_STEP_US : POS_STEP_US);
        if (!s.mode)    w = 15'd1000 + mag;
        else if (s.dir) w = 15'd1500 + mag;
        else            w = 15'd1500 - mag;
        if (w < 15'd500)       w = 15'd500;
        else if (w > 15'd2500) w = 15'd2500;
        return w;
    endfunction

    function automatic logic [14:0] slew_step(input logic [14:0] cur, input logic [14:0] tgt);
        if (SLEW_US == 0)
            return tgt;
        if (tgt > cur)
            return ((tgt - cur) > 15'(SLEW_US)) ? cur + 15'(SLEW_US) : tgt;
        return ((cur - tgt) > 15'(SLEW_US)) ? cur - 15'(SLEW_US) : tgt;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q         <= '0;
            frame_us_q    <= '0;
            frame_start_q <= 1'b0;
            ena_q         <= '0;
            pulse_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                target_q[i] <= 15'd1500;
                cur_w_q[i]  <= 15'd1500;
            end
        end else begin
            pre_q         <= pre_d;
            frame_us_q    <= frame_us_d;
            frame_start_q <= frame_start_d;
            ena_q         <= ena_d;
            pulse_q       <= pulse_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                target_q[i] <= target_d[i];
                cur_w_q[i]  <= cur_w_d[i];
            end
        end
    end

    always_comb begin
        tick          = (pre_q == PRE_W'(DIV - 1));
        pre_d         = tick ? '0 : pre_q + PRE_W'(1);
        wrap          = tick && (frame_us_q == 15'd19999);
        frame_us_d    = frame_us_q;
        if (tick)
            frame_us_d = wrap ? 15'd0 : frame_us_q + 15'd1;
        frame_start_d = wrap;
        ena_d         = ena_q;
        pulse_d       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // The boundary samples the pre-write shadow, so a write on the wrap clk waits a frame.
            shadow_d[i] = shadow_q[i];
            if (wr_en_i && (wr_ch_i == CH_W'(i)))
                shadow_d[i] = '{mode: wr_mode_i, dir: wr_dir_i, cmd: wr_cmd_i, ena: wr_ena_i};
            target_d[i] = target_q[i];
            cur_w_d[i]  = cur_w_q[i];
            if (wrap) begin
                target_d[i] = calc_target(shadow_q[i]);
                cur_w_d[i]  = slew_step(cur_w_q[i], target_d[i]);
                ena_d[i]    = shadow_q[i].ena;
            end
            pulse_d[i] = ena_q[i] && (frame_us_q < cur_w_q[i]);
        end
    end

    assign pulse_o       = pulse_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench: three instances differing only in slew limit share one command bus.
module tb_servo_pwm_array;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic       wr_mode = 1'b0;
    logic       wr_dir = 1'b0;
    logic [5:0] wr_cmd = '0;
    logic       wr_ena = 1'b0;
    logic [3:0] p0, ps, pt;
    logic       fs0, fss, fst;

    int total = 0;
    int bad   = 0;
    int c0[4], cs[4], ct[4];
    int first0, fs_first, n, hi;

    always #5 clk = ~clk;

    servo_pwm_array #(.NUM_CH(4), .CMD_W(6), .SIMULATE(1), .SLEW_US(0), .CH_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_mode_i(wr_mode),
        .wr_dir_i(wr_dir), .wr_cmd_i(wr_cmd), .wr_ena_i(wr_ena), .pulse_o(p0), .frame_start_o(fs0));

    servo_pwm_array #(.NUM_CH(4), .CMD_W(6), .SIMULATE(1), .SLEW_US(64), .CH_W(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_mode_i(wr_mode),
        .wr_dir_i(wr_dir), .wr_cmd_i(wr_cmd), .wr_ena_i(wr_ena), .pulse_o(ps), .frame_start_o(fss));

    servo_pwm_array #(.NUM_CH(4), .CMD_W(6), .SIMULATE(1), .SLEW_US(300), .CH_W(3)) dut_t (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_mode_i(wr_mode),
        .wr_dir_i(wr_dir), .wr_cmd_i(wr_cmd), .wr_ena_i(wr_ena), .pulse_o(pt), .frame_start_o(fst));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int ch, input int mode, input int dir, input int cmd, input int ena);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_mode = 1'(mode);
        wr_dir  = 1'(dir);
        wr_cmd  = 6'(cmd);
        wr_ena  = 1'(ena);
    endtask

    task automatic wr(input int ch, input int mode, input int dir, input int cmd, input int ena);
        set_wr(ch, mode, dir, cmd, ena);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Counts clocks since reset release until frame_start; optionally writes on the wrap clk.
    task automatic count_to_fs(input int n0, input bit bwr, output int cnt, output int high);
        cnt  = n0;
        high = 0;
        do begin
            if (bwr && cnt == 19999)
                set_wr(1, 1, 0, 63, 1);
            @(posedge clk); #1;
            cnt++;
            if (cnt == 20000)
                wr_en = 1'b0;
            high += int'(|{p0, ps, pt});
        end while (!fs0 && cnt < 20010);
    endtask

    // Measures one full frame of high time per channel, starting just after a frame_start.
    task automatic meas();
        for (int c = 0; c < 4; c++) begin
            c0[c] = 0; cs[c] = 0; ct[c] = 0;
        end
        for (int k = 1; k <= 20000; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                first0   = int'(p0[0]);
                fs_first = int'(fs0);
            end
            for (int c = 0; c < 4; c++) begin
                c0[c] += int'(p0[c]);
                cs[c] += int'(ps[c]);
                ct[c] += int'(pt[c]);
            end
        end
        chk("fs_period", int'(fs0), 1);
        chk("fs_one_clk", fs_first, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulse", int'({pt, ps, p0}), 0);
        chk("rst_fs", int'(fs0), 0);
        rst = 1'b0;

        wr(0, 0, 0, 63, 1);
        wr(1, 1, 1, 63, 1);
        wr(2, 0, 0, 0, 1);
        wr(3, 0, 0, 10, 1);
        wr(3, 0, 0, 20, 1);
        wr(5, 0, 0, 0, 0);
        count_to_fs(6, 1'b1, n, hi);
        chk("rst_first_fs_clk", n, 20000);
        chk("rst_no_pulse", hi, 0);

        // Frame 1: commands written in the reset frame are live.
        chk("lag_on_fs", int'(p0[0]), 0);
        meas();
        chk("lag_next_clk", first0, 1);
        chk("pos_max_w", c0[0], 1945);
        chk("rot_cw_w", c0[1], 1941);
        chk("pos_min_w", c0[2], 1000);
        chk("last_wins_w", c0[3], 1300);
        chk("slew64_f1", cs[2], 1436);
        chk("slew300_dn_f1", ct[2], 1200);
        chk("slew300_up_f1", ct[0], 1800);

        // Frame 2: boundary-clk write to ch1 now applied.
        meas();
        chk("rot_ccw_w", c0[1], 1059);
        chk("pos_max_hold", c0[0], 1945);
        chk("last_wins_hold", c0[3], 1300);
        chk("slew64_f2", cs[2], 1372);
        chk("slew300_dn_f2", ct[2], 1000);
        chk("slew300_up_f2", ct[0], 1945);
        chk("slew300_rot_f2", ct[1], 1500);

        // Frame 3: reset while ch0 is high.
        repeat (10) @(posedge clk);
        #1;
        chk("mid_pulse_high", int'(p0[0]), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_low", int'({pt, ps, p0}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        count_to_fs(0, 1'b0, n, hi);
        chk("rerst_fs_clk", n, 20000);
        chk("rerst_no_pulse", hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
